// File: rtl/quad_pkg.sv
// Shared constants for the quadrature input filter.
// Widths, parameter defaults and legal ranges.
`timescale 1ns/1ps
package quad_pkg;
  localparam int GLITCH_CNT_W   = 8;
  localparam int FILTER_LEN_DEF = 4;
  localparam int PRESCALE_DEF   = 1;
  localparam int FILTER_LEN_MIN = 1;
  localparam int FILTER_LEN_MAX = 64;
  localparam int PRESCALE_MIN   = 1;
  localparam int PRESCALE_MAX   = 65536;

  // Counter width for values 0..n-1, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/quad_chan_filter.sv
// One encoder channel: 2-flop synchronizer plus persistence filter.
// Emits toggle and glitch strobes for the top-level bookkeeping.
`timescale 1ns/1ps
module quad_chan_filter
  import quad_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  output logic filt,
  output logic toggle,
  output logic glitch
);
  localparam int SW = cnt_w(FILTER_LEN);
  localparam logic [SW-1:0] LAST = SW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic [SW-1:0] stable;
  logic          synced;
  logic          differ;

  assign synced = sync_q[1];
  assign differ = synced ^ filt;
  assign toggle = tick & differ & (stable == LAST);
  // Level fell back before acceptance: a rejected glitch.
  assign glitch = tick & ~differ & (stable != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      stable <= '0;
      filt   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (tick) begin
        if (!differ || stable == LAST) begin
          stable <= '0;
        end else begin
          stable <= stable + 1'b1;
        end
      end
      if (toggle) begin
        filt <= ~filt;
      end
    end
  end
endmodule

// File: rtl/quad_input_filter.sv
// Two-channel quadrature input filter with prescaled sampling,
// change/error strobes and a saturating glitch counter.
`timescale 1ns/1ps
module quad_input_filter
  import quad_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF,
  parameter int PRESCALE   = PRESCALE_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    chn_a,
  input  logic                    chn_b,
  input  logic                    clr,
  output logic                    chn_a_f,
  output logic                    chn_b_f,
  output logic                    chg,
  output logic                    err_pulse,
  output logic                    err_sticky,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);
  if (FILTER_LEN < FILTER_LEN_MIN || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_len
    $error("FILTER_LEN out of range");
  end
  if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_pre
    $error("PRESCALE out of range");
  end

  localparam int PW = cnt_w(PRESCALE);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  localparam logic [GLITCH_CNT_W-1:0] CNT_MAX = '1;

  logic [PW-1:0] pre;
  logic          tick;
  logic          tog_a, tog_b;
  logic          gl_a, gl_b;
  logic [1:0]    gl_n;
  logic [GLITCH_CNT_W-1:0] cnt_base;
  logic [GLITCH_CNT_W:0]   cnt_sum;
  logic [GLITCH_CNT_W-1:0] cnt_next;

  assign tick = (pre == PLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

  quad_chan_filter #(.FILTER_LEN(FILTER_LEN)) u_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (chn_a),
    .tick   (tick),
    .filt   (chn_a_f),
    .toggle (tog_a),
    .glitch (gl_a)
  );

  quad_chan_filter #(.FILTER_LEN(FILTER_LEN)) u_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (chn_b),
    .tick   (tick),
    .filt   (chn_b_f),
    .toggle (tog_b),
    .glitch (gl_b)
  );

  // Clear drops the old count but still keeps this cycle's events.
  always_comb begin
    gl_n     = {1'b0, gl_a} + {1'b0, gl_b};
    cnt_base = clr ? '0 : glitch_cnt;
    cnt_sum  = {1'b0, cnt_base} + {{(GLITCH_CNT_W-1){1'b0}}, gl_n};
    cnt_next = cnt_sum[GLITCH_CNT_W] ? CNT_MAX : cnt_sum[GLITCH_CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg        <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      chg        <= tog_a | tog_b;
      err_pulse  <= tog_a & tog_b;
      glitch_cnt <= cnt_next;
      if (tog_a && tog_b) begin
        err_sticky <= 1'b1;
      end else if (clr) begin
        err_sticky <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_quad_input_filter.sv
// Directed bench: default filter plus a PRESCALE=4/FILTER_LEN=2 copy.
// Expected values are hand-derived edge counts from input changes.
`timescale 1ns/1ps
module tb_quad_input_filter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       chn_a = 1'b0, chn_b = 1'b0, clr = 1'b0;
  logic       chn_a_f, chn_b_f, chg, err_pulse, err_sticky;
  logic [7:0] glitch_cnt;
  logic       chn_a2 = 1'b0, chn_b2 = 1'b0, clr2 = 1'b0;
  logic       chn_a_f2, chn_b_f2, chg2, err_pulse2, err_sticky2;
  logic [7:0] glitch_cnt2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  quad_input_filter #(.FILTER_LEN(4), .PRESCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .chn_a(chn_a), .chn_b(chn_b), .clr(clr),
    .chn_a_f(chn_a_f), .chn_b_f(chn_b_f), .chg(chg),
    .err_pulse(err_pulse), .err_sticky(err_sticky),
    .glitch_cnt(glitch_cnt)
  );

  quad_input_filter #(.FILTER_LEN(2), .PRESCALE(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .chn_a(chn_a2), .chn_b(chn_b2), .clr(clr2),
    .chn_a_f(chn_a_f2), .chn_b_f(chn_b_f2), .chg(chg2),
    .err_pulse(err_pulse2), .err_sticky(err_sticky2),
    .glitch_cnt(glitch_cnt2)
  );

  // Leaves the bench 1 time unit after "edge 0" with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({chn_a_f, chn_b_f, chg, err_pulse, err_sticky} !== 5'b0 ||
        glitch_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset: a_f=%b b_f=%b chg=%b ep=%b es=%b gc=%0d required all 0",
               chn_a_f, chn_b_f, chg, err_pulse, err_sticky, glitch_cnt);
    end
    do_reset();
  endtask

  task automatic test_rise();
    @(posedge clk); #1 chn_a = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (chn_a_f !== 1'b0 || chg !== 1'b0) begin
      failures++;
      $display("FAIL rise_early: a_f=%b chg=%b required 0 0", chn_a_f, chg);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (chn_a_f !== 1'b1 || chg !== 1'b1 || err_pulse !== 1'b0) begin
      failures++;
      $display("FAIL rise_edge: a_f=%b chg=%b ep=%b required 1 1 0",
               chn_a_f, chg, err_pulse);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (chn_a_f !== 1'b1 || chg !== 1'b0 || glitch_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rise_after: a_f=%b chg=%b gc=%0d required 1 0 0",
               chn_a_f, chg, glitch_cnt);
    end
  endtask

  task automatic b_pulse3();
    @(posedge clk); #1 chn_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 chn_b = 1'b0;
  endtask

  task automatic test_glitch();
    b_pulse3();
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (chn_b_f !== 1'b0 || glitch_cnt !== 8'd1 || chg !== 1'b0) begin
      failures++;
      $display("FAIL glitch_one: b_f=%b gc=%0d chg=%b required 0 1 0",
               chn_b_f, glitch_cnt, chg);
    end
    for (int i = 0; i < 299; i++) begin
      b_pulse3();
      repeat (5) @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (chn_b_f !== 1'b0 || glitch_cnt !== 8'd255) begin
      failures++;
      $display("FAIL glitch_sat: b_f=%b gc=%0d required 0 255",
               chn_b_f, glitch_cnt);
    end
  endtask

  task automatic test_clr_glitch();
    b_pulse3();
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    checks++;
    if (glitch_cnt !== 8'd1) begin
      failures++;
      $display("FAIL clr_with_glitch: gc=%0d required 1", glitch_cnt);
    end
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    checks++;
    if (glitch_cnt !== 8'd0 || chn_a_f !== 1'b1) begin
      failures++;
      $display("FAIL clr_plain: gc=%0d a_f=%b required 0 1",
               glitch_cnt, chn_a_f);
    end
  endtask

  task automatic test_err();
    chn_a = 1'b0; chn_b = 1'b0;
    do_reset();
    chn_a = 1'b1; chn_b = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (chn_a_f !== 1'b0 || chn_b_f !== 1'b0 || err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL err_early: a_f=%b b_f=%b es=%b required 0 0 0",
               chn_a_f, chn_b_f, err_sticky);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if ({chn_a_f, chn_b_f, chg, err_pulse, err_sticky} !== 5'b11111) begin
      failures++;
      $display("FAIL err_edge: a_f=%b b_f=%b chg=%b ep=%b es=%b required 11111",
               chn_a_f, chn_b_f, chg, err_pulse, err_sticky);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (err_pulse !== 1'b0 || chg !== 1'b0 || err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL err_after: ep=%b chg=%b es=%b required 0 0 1",
               err_pulse, chg, err_sticky);
    end
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    checks++;
    if (err_sticky !== 1'b0 || chn_a_f !== 1'b1) begin
      failures++;
      $display("FAIL err_clr: es=%b a_f=%b required 0 1", err_sticky, chn_a_f);
    end
    chn_a = 1'b0; chn_b = 1'b0;
    repeat (5) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    checks++;
    if ({chn_a_f, chn_b_f, err_pulse, err_sticky} !== 4'b0011) begin
      failures++;
      $display("FAIL err_clr_same: a_f=%b b_f=%b ep=%b es=%b required 0011",
               chn_a_f, chn_b_f, err_pulse, err_sticky);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1 chn_a = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({chn_a_f, chn_b_f, chg, err_pulse, err_sticky} !== 5'b0 ||
        glitch_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_async: a_f=%b es=%b gc=%0d required 0 0 0",
               chn_a_f, err_sticky, glitch_cnt);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (chn_a_f !== 1'b0 || chg !== 1'b0) begin
      failures++;
      $display("FAIL reset_rel_early: a_f=%b chg=%b required 0 0", chn_a_f, chg);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (chn_a_f !== 1'b1 || chg !== 1'b1 || glitch_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_rel_rise: a_f=%b chg=%b gc=%0d required 1 1 0",
               chn_a_f, chg, glitch_cnt);
    end
  endtask

  task automatic test_prescale();
    // Ticks land on edges 4, 8, 12 ... after release.
    chn_a2 = 1'b0;
    do_reset();
    chn_a2 = 1'b1;
    repeat (6) @(posedge clk);
    #1 chn_a2 = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (chn_a_f2 !== 1'b0) begin
      failures++;
      $display("FAIL pre6_acc_early: a_f=%b required 0", chn_a_f2);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (chn_a_f2 !== 1'b1 || chg2 !== 1'b1) begin
      failures++;
      $display("FAIL pre6_acc_rise: a_f=%b chg=%b required 1 1", chn_a_f2, chg2);
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++;
    if (chn_a_f2 !== 1'b0 || glitch_cnt2 !== 8'd0) begin
      failures++;
      $display("FAIL pre6_acc_fall: a_f=%b gc=%0d required 0 0",
               chn_a_f2, glitch_cnt2);
    end
    do_reset();
    repeat (2) @(posedge clk);
    #1 chn_a2 = 1'b1;
    repeat (6) @(posedge clk);
    #1 chn_a2 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (chn_a_f2 !== 1'b0 || glitch_cnt2 !== 8'd1) begin
      failures++;
      $display("FAIL pre6_rej: a_f=%b gc=%0d required 0 1",
               chn_a_f2, glitch_cnt2);
    end
    do_reset();
    repeat (3) @(posedge clk);
    #1 chn_a2 = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++;
    if (chn_a_f2 !== 1'b0) begin
      failures++;
      $display("FAIL pre12_early: a_f=%b required 0", chn_a_f2);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (chn_a_f2 !== 1'b1) begin
      failures++;
      $display("FAIL pre12_rise: a_f=%b required 1", chn_a_f2);
    end
    repeat (3) @(posedge clk);
    #1 chn_a2 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    checks++;
    if (chn_a_f2 !== 1'b0 || glitch_cnt2 !== 8'd0 ||
        {chn_b_f2, err_pulse2, err_sticky2} !== 3'b0) begin
      failures++;
      $display("FAIL pre12_fall: a_f=%b gc=%0d b/ep/es=%b%b%b required 0 0 000",
               chn_a_f2, glitch_cnt2, chn_b_f2, err_pulse2, err_sticky2);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_clr_glitch();
    test_err();
    test_reset_mid();
    test_prescale();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
